// File: rtl/clk_drive_scheduler.sv
// Cycle-based drive scheduler: timed drive requests are released onto drv_d on their due edge,
// and the sampled DUT output comes back on cb_q after IN_SKEW cycles. Optional flush port: CLK_DRIVE_SCHEDULER_FLUSH_EN.
module clk_drive_scheduler #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 4,
  parameter int DELAY_W = 4,
  parameter int IN_SKEW = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [WIDTH-1:0]             req_data,
  input  logic [DELAY_W-1:0]           req_delay,
`ifdef CLK_DRIVE_SCHEDULER_FLUSH_EN
  input  logic                         flush,
`endif
  output logic [WIDTH-1:0]             drv_d,
  output logic                         drv_strobe,
  input  logic [WIDTH-1:0]             smp_q,
  output logic [WIDTH-1:0]             cb_q,
  output logic [$clog2(DEPTH+1)-1:0]   pend_count,
  output logic                         collision
);

  localparam int CNT_W = $clog2(DEPTH+1);

  // Handshake: a request transfers on an edge where req_valid && req_ready; the requester
  // holds req_valid and its payload stable until then. req_ready depends only on registered
  // state plus rst/flush, never on req_*.

  logic                  flush_i;
  logic [DEPTH-1:0]      slot_vld;
  logic [DELAY_W-1:0]    slot_cnt  [DEPTH];
  logic [WIDTH-1:0]      slot_data [DEPTH];
  logic [DEPTH-1:0]      older     [DEPTH];  // older[r][c]: slot r was accepted before slot c
  logic [CNT_W-1:0]      pend_cnt_r;
  logic [WIDTH-1:0]      skew_pipe [IN_SKEW+1];

  logic                  accept;
  logic                  acc_bypass;
  logic                  acc_slot;
  logic [DEPTH-1:0]      due;
  logic [DEPTH-1:0]      win;
  logic [DEPTH-1:0]      alloc;
  logic [CNT_W-1:0]      n_fired;
  logic [WIDTH-1:0]      win_data;
  logic                  multi_due;

`ifdef CLK_DRIVE_SCHEDULER_FLUSH_EN
  assign flush_i = flush;
`else
  assign flush_i = 1'b0;
`endif

  assign req_ready  = !rst && !flush_i && (pend_cnt_r < CNT_W'(DEPTH));
  assign accept     = req_valid && req_ready;
  assign acc_bypass = accept && (req_delay == '0);
  assign acc_slot   = accept && (req_delay != '0);
  assign pend_count = pend_cnt_r;
  assign cb_q       = skew_pipe[IN_SKEW];

  always_comb begin
    due     = '0;
    n_fired = '0;
    for (int i = 0; i < DEPTH; i++) begin
      due[i]  = slot_vld[i] && (slot_cnt[i] == DELAY_W'(1));
      n_fired = n_fired + CNT_W'(due[i]);
    end
  end

  // The winning slot is the due slot that no other due slot is younger than.
  always_comb begin
    win = '0;
    for (int i = 0; i < DEPTH; i++) begin
      win[i] = due[i];
      for (int j = 0; j < DEPTH; j++) begin
        if ((j != i) && due[j] && older[i][j]) win[i] = 1'b0;
      end
    end
  end

  always_comb begin
    win_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (win[i]) win_data = slot_data[i];
    end
  end

  always_comb begin : lowest_free
    logic found;
    found = 1'b0;
    alloc = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!slot_vld[i] && !found) begin
        alloc[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  assign multi_due = (n_fired > CNT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_vld   <= '0;
      pend_cnt_r <= '0;
      drv_d      <= '0;
      drv_strobe <= 1'b0;
      collision  <= 1'b0;
    end else begin
      drv_strobe <= 1'b0;
      collision  <= 1'b0;
      if (flush_i) begin
        slot_vld   <= '0;
        pend_cnt_r <= '0;
      end else begin
        if (acc_bypass) begin
          drv_d      <= req_data;
          drv_strobe <= 1'b1;
          collision  <= |due;
        end else if (|due) begin
          drv_d      <= win_data;
          drv_strobe <= 1'b1;
          collision  <= multi_due;
        end
        pend_cnt_r <= pend_cnt_r + CNT_W'(acc_slot) - n_fired;
        for (int i = 0; i < DEPTH; i++) begin
          if (due[i]) begin
            slot_vld[i] <= 1'b0;
          end else if (slot_vld[i]) begin
            slot_cnt[i] <= slot_cnt[i] - DELAY_W'(1);
          end
          if (acc_slot && alloc[i]) begin
            slot_vld[i]  <= 1'b1;
            slot_cnt[i]  <= req_delay;
            slot_data[i] <= req_data;
          end
        end
      end
    end
  end

  // A newly allocated slot becomes younger than every other slot.
  always_ff @(posedge clk) begin
    if (acc_slot) begin
      for (int r = 0; r < DEPTH; r++) begin
        for (int c = 0; c < DEPTH; c++) begin
          if (alloc[c] && (r != c)) older[r][c] <= 1'b1;
          else if (alloc[r])        older[r][c] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k <= IN_SKEW; k++) skew_pipe[k] <= '0;
    end else begin
      skew_pipe[0] <= smp_q;
      for (int k = 1; k <= IN_SKEW; k++) skew_pipe[k] <= skew_pipe[k-1];
    end
  end

endmodule

// File: tb/tb_clk_drive_scheduler.sv
// Scoreboard bench for clk_drive_scheduler: a queue-based reference model predicts drives, collisions,
// occupancy and skewed samples; a monitor pops expectations whenever drv_strobe is presented.
module tb_clk_drive_scheduler;

  localparam int WIDTH   = 8;
  localparam int DEPTH   = 4;
  localparam int DELAY_W = 4;
  localparam int IN_SKEW = 3;

  logic               clk;
  logic               rst;
  logic               req_valid;
  logic               req_ready;
  logic [WIDTH-1:0]   req_data;
  logic [DELAY_W-1:0] req_delay;
  logic               flush_s;
  logic [WIDTH-1:0]   drv_d;
  logic               drv_strobe;
  logic [WIDTH-1:0]   smp_q;
  logic [WIDTH-1:0]   cb_q;
  logic [2:0]         pend_count;
  logic               collision;

  logic               req_ready0;
  logic [WIDTH-1:0]   drv_d0;
  logic               drv_strobe0;
  logic [WIDTH-1:0]   cb_q0;
  logic [2:0]         pend_count0;
  logic               collision0;

  clk_drive_scheduler #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DELAY_W(DELAY_W), .IN_SKEW(IN_SKEW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_delay(req_delay),
`ifdef CLK_DRIVE_SCHEDULER_FLUSH_EN
    .flush(flush_s),
`endif
    .drv_d(drv_d), .drv_strobe(drv_strobe), .smp_q(smp_q), .cb_q(cb_q),
    .pend_count(pend_count), .collision(collision)
  );

  clk_drive_scheduler #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DELAY_W(DELAY_W), .IN_SKEW(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready0),
    .req_data(req_data), .req_delay(req_delay),
`ifdef CLK_DRIVE_SCHEDULER_FLUSH_EN
    .flush(flush_s),
`endif
    .drv_d(drv_d0), .drv_strobe(drv_strobe0), .smp_q(smp_q), .cb_q(cb_q0),
    .pend_count(pend_count0), .collision(collision0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int             due;
    logic [WIDTH-1:0] data;
    int             seq;
  } pend_t;

  pend_t            pend[$];
  logic [WIDTH:0]   exp_q[$];      // {collision, drv_d}
  logic [WIDTH-1:0] hist[$];       // smp_q sampled at post-reset edges, newest last
  logic [WIDTH-1:0] hold_val;
  logic [WIDTH-1:0] smp_val;
  logic             smp_random;
  logic             armed;
  int               cyc;
  int               seq_ctr;
  int               total;
  int               bad;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference model of one clock edge, from the scheduling rules.
  task automatic model_edge(input logic r, input logic f, input logic acc,
                            input logic [WIDTH-1:0] d, input logic [DELAY_W-1:0] dl,
                            input logic [WIDTH-1:0] s);
    int n;
    int best;
    logic [WIDTH-1:0] wd;
    cyc++;
    if (r) begin
      pend.delete();
      exp_q.delete();
      hist.delete();
      hold_val = '0;
      armed    = 1'b1;
      return;
    end
    hist.push_back(s);
    if (hist.size() > IN_SKEW + 1) void'(hist.pop_front());
    if (f) begin
      pend.delete();
      return;
    end
    n    = 0;
    best = -1;
    wd   = '0;
    foreach (pend[i]) begin
      if (pend[i].due == cyc) begin
        n++;
        if (pend[i].seq > best) begin
          best = pend[i].seq;
          wd   = pend[i].data;
        end
      end
    end
    if (acc && dl == 0) begin
      n++;
      wd = d;
    end
    if (n > 0) exp_q.push_back({(n > 1), wd});
    for (int i = pend.size() - 1; i >= 0; i--) begin
      if (pend[i].due == cyc) pend.delete(i);
    end
    if (acc && dl != 0) begin
      pend.push_back('{cyc + int'(dl), d, seq_ctr});
      seq_ctr++;
    end
  endtask

  task automatic cycle_once(input logic v, input logic [WIDTH-1:0] d, input logic [DELAY_W-1:0] dl,
                            input logic r, input logic f, output logic acc);
    logic m_ready;
    logic [WIDTH-1:0] exp_cb;
    logic [WIDTH-1:0] exp_cb0;
    @(negedge clk);
    if (smp_random) smp_val = WIDTH'($urandom);
    rst       = r;
    req_valid = v;
    req_data  = d;
    req_delay = dl;
    flush_s   = f;
    smp_q     = smp_val;
    m_ready   = !r && !f && (pend.size() < DEPTH);
    #1;
    chk("req_ready", req_ready, m_ready);
    acc = v && m_ready;
    @(posedge clk);
    model_edge(r, f, acc, d, dl, smp_val);
    #1;
    exp_cb  = (hist.size() == IN_SKEW + 1) ? hist[0] : '0;
    exp_cb0 = (hist.size() > 0) ? hist[hist.size()-1] : '0;
    chk("pend_count", pend_count, pend.size());
    chk("cb_q", cb_q, exp_cb);
    chk("cb_q_skew0", cb_q0, exp_cb0);
  endtask

  task automatic send(input logic [WIDTH-1:0] d, input logic [DELAY_W-1:0] dl);
    logic acc;
    int n;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 200) begin
      cycle_once(1'b1, d, dl, 1'b0, 1'b0, acc);
      n++;
    end
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL send_timeout: request 0x%0h not accepted within %0d cycles", d, n);
    end
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) cycle_once(1'b0, '0, '0, 1'b0, 1'b0, acc);
  endtask

  task automatic do_reset(input int n);
    logic acc;
    for (int i = 0; i < n; i++) cycle_once(1'b0, '0, '0, 1'b1, 1'b0, acc);
  endtask

  // Monitor: a strobe is expected exactly when the model queued a drive on the last edge.
  always @(negedge clk) begin
    logic [WIDTH:0] e;
    logic exp_pending;
    if (armed) begin
      exp_pending = (exp_q.size() != 0);
      chk("drv_strobe", drv_strobe, exp_pending);
      if (exp_pending) begin
        e = exp_q.pop_front();
        chk("drv_d", drv_d, e[WIDTH-1:0]);
        chk("collision", collision, e[WIDTH]);
        hold_val = e[WIDTH-1:0];
      end else begin
        chk("drv_d_hold", drv_d, hold_val);
        chk("collision_idle", collision, 1'b0);
      end
    end
  end

  initial begin
    logic acc;
    logic have;
    logic r;
    logic f;
    logic [WIDTH-1:0] rd;
    logic [DELAY_W-1:0] rdl;
    total = 0; bad = 0; cyc = 0; seq_ctr = 0;
    armed = 1'b0; hold_val = '0; smp_random = 1'b1; smp_val = '0;
    rst = 1'b1; req_valid = 1'b0; req_data = '0; req_delay = '0; flush_s = 1'b0; smp_q = '0;

    do_reset(3);
    idle(2);

    // Reset discards pending drives
    send(8'h11, 4'd10);
    send(8'h22, 4'd12);
    idle(2);
    do_reset(1);
    idle(16);

    // Delay sweep
    send(8'h01, 4'd0);
    send(8'h02, 4'd1);
    send(8'h04, 4'd3);
    idle(6);

    // Full table with a held fifth request
    send(8'h10, 4'd15);
    send(8'h20, 4'd15);
    send(8'h30, 4'd15);
    send(8'h40, 4'd15);
    send(8'h50, 4'd15);
    idle(20);

    // Collisions, slot-only then with bypass
    send(8'hAA, 4'd3);
    send(8'h55, 4'd2);
    idle(4);
    send(8'hAA, 4'd3);
    send(8'h55, 4'd2);
    idle(1);
    send(8'h0F, 4'd0);
    idle(4);

    // Input skew step
    smp_random = 1'b0;
    smp_val    = 8'h00;
    idle(5);
    smp_val    = 8'h3C;
    idle(6);
    smp_random = 1'b1;

`ifdef CLK_DRIVE_SCHEDULER_FLUSH_EN
    send(8'hA1, 4'd3);
    send(8'hB2, 4'd6);
    send(8'hC3, 4'd6);
    cycle_once(1'b0, '0, '0, 1'b0, 1'b1, acc);
    idle(10);
`endif

    // Randomized traffic with held requests, occasional reset and flush
    have = 1'b0;
    rd   = '0;
    rdl  = '0;
    for (int c = 0; c < 1500; c++) begin
      if (!have && $urandom_range(0, 2) != 0) begin
        have = 1'b1;
        rd   = WIDTH'($urandom);
        rdl  = ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 5));
      end
      r = ($urandom_range(0, 299) == 0);
      f = 1'b0;
`ifdef CLK_DRIVE_SCHEDULER_FLUSH_EN
      f = ($urandom_range(0, 49) == 0);
`endif
      cycle_once(have, rd, rdl, r, f, acc);
      if (acc) have = 1'b0;
    end
    idle(20);
    chk("exp_q_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
